// File: rtl/spi_link_pkg.sv
// Shared constants for the round-robin serial link scheduler: FSM encodings,
// frame bit values, response error codes and a width helper.
package spi_link_pkg;

   localparam int unsigned ST_W = 3;

   localparam logic [ST_W-1:0] S_IDLE      = 3'd0;
   localparam logic [ST_W-1:0] S_START     = 3'd1;
   localparam logic [ST_W-1:0] S_TX_DATA   = 3'd2;
   localparam logic [ST_W-1:0] S_TX_STOP   = 3'd3;
   localparam logic [ST_W-1:0] S_RESP_WAIT = 3'd4;
   localparam logic [ST_W-1:0] S_RESP_DATA = 3'd5;
   localparam logic [ST_W-1:0] S_RESP_STOP = 3'd6;
   localparam logic [ST_W-1:0] S_GAP       = 3'd7;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_FRAME   = 2'b10;

   // Index width that stays legal for a single requester.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_link_sched_if.sv
// Requester-side bus and serial pins of the link scheduler.
interface spi_link_sched_if #(
   parameter int unsigned NREQ = 2
) ();
   import spi_link_pkg::*;

   localparam int unsigned IDW = idx_w(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ*8-1:0] req_data;
   logic [NREQ-1:0]   grant;
   logic              resp_valid;
   logic [IDW-1:0]    resp_id;
   logic [7:0]        resp_data;
   logic [1:0]        resp_err;
   logic              busy;
   logic              spi_cs_n;
   logic              spi_mosi;
   logic              spi_miso;

   modport master (
      output req_valid, req_data, spi_miso,
      input  grant, resp_valid, resp_id, resp_data, resp_err, busy, spi_cs_n, spi_mosi
   );

   modport slave (
      input  req_valid, req_data, spi_miso,
      output grant, resp_valid, resp_id, resp_data, resp_err, busy, spi_cs_n, spi_mosi
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after i_ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IDW  = 1
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   output logic [NREQ-1:0] o_grant_c,
   output logic [IDW-1:0]  o_idx_c,
   output logic            o_any_c
);

   logic [IDW-1:0] w_j;

   always_comb begin
      o_grant_c = '0;
      o_idx_c   = '0;
      o_any_c   = 1'b0;
      w_j       = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         w_j = IDW'((32'(i_ptr) + k) % NREQ);
         if (!o_any_c && i_req[w_j]) begin
            o_any_c        = 1'b1;
            o_idx_c        = w_j;
            o_grant_c[w_j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_link_sched.sv
// Shares one serial MOSI/MISO link among NREQ requesters: sends the granted
// byte as a start/8-data/stop frame, then returns the peer's response frame.
module spi_link_sched
   import spi_link_pkg::*;
#(
   parameter int unsigned NREQ       = 2,
   parameter int unsigned TIMEOUT    = 32,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic          spi_clk,
   input  logic          rst_n,
   spi_link_sched_if.slave bus
);

   localparam int unsigned IDW = idx_w(NREQ);
   localparam int unsigned TCW = $clog2(TIMEOUT + 1);
   localparam int unsigned GCW = $clog2(GAP_CYCLES + 1);

   logic [ST_W-1:0] r_state,      w_state_nxt;
   logic [IDW-1:0]  r_ptr,        w_ptr_nxt;
   logic [7:0]      r_tx,         w_tx_nxt;
   logic [IDW-1:0]  r_id,         w_id_nxt;
   logic [2:0]      r_bit_cnt,    w_bit_cnt_nxt;
   logic [TCW-1:0]  r_tmo_cnt,    w_tmo_cnt_nxt;
   logic [GCW-1:0]  r_gap_cnt,    w_gap_cnt_nxt;
   logic [7:0]      r_rx,         w_rx_nxt;
   logic [NREQ-1:0] r_grant,      w_grant_nxt;
   logic            r_resp_valid, w_resp_valid_nxt;
   logic [IDW-1:0]  r_resp_id,    w_resp_id_nxt;
   logic [7:0]      r_resp_data,  w_resp_data_nxt;
   logic [1:0]      r_resp_err,   w_resp_err_nxt;
   logic            r_busy,       w_busy_nxt;
   logic            r_cs_n,       w_cs_n_nxt;
   logic            r_mosi,       w_mosi_nxt;

   logic [NREQ-1:0] w_win_oh;
   logic [IDW-1:0]  w_win_idx;
   logic            w_win_any;
   logic [7:0]      w_sel_byte;
   logic            w_finish;
   logic [7:0]      w_fin_data;
   logic [1:0]      w_fin_err;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .i_req     (bus.req_valid),
      .i_ptr     (r_ptr),
      .o_grant_c (w_win_oh),
      .o_idx_c   (w_win_idx),
      .o_any_c   (w_win_any)
   );

   assign w_sel_byte = bus.req_data[{w_win_idx, 3'b000} +: 8];

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt      = r_state;
      w_ptr_nxt        = r_ptr;
      w_tx_nxt         = r_tx;
      w_id_nxt         = r_id;
      w_bit_cnt_nxt    = r_bit_cnt;
      w_tmo_cnt_nxt    = r_tmo_cnt;
      w_gap_cnt_nxt    = r_gap_cnt;
      w_rx_nxt         = r_rx;
      w_grant_nxt      = '0;
      w_resp_valid_nxt = 1'b0;
      w_resp_id_nxt    = r_resp_id;
      w_resp_data_nxt  = r_resp_data;
      w_resp_err_nxt   = r_resp_err;
      w_busy_nxt       = r_busy;
      w_cs_n_nxt       = r_cs_n;
      w_mosi_nxt       = r_mosi;
      w_finish         = 1'b0;
      w_fin_data       = 8'h00;
      w_fin_err        = ERR_OK;

      case (r_state)
         S_IDLE: begin
            if (w_win_any) begin
               w_ptr_nxt   = w_win_idx;
               w_tx_nxt    = w_sel_byte;
               w_id_nxt    = w_win_idx;
               w_grant_nxt = w_win_oh;
               w_state_nxt = S_START;
               w_cs_n_nxt  = 1'b0;
               w_mosi_nxt  = START_BIT;
               w_busy_nxt  = 1'b1;
            end
         end
         S_START: begin
            w_mosi_nxt    = r_tx[7];
            w_bit_cnt_nxt = 3'd1;
            w_state_nxt   = S_TX_DATA;
         end
         S_TX_DATA: begin
            w_mosi_nxt = r_tx[3'd7 - r_bit_cnt];
            if (r_bit_cnt == 3'd7) begin
               w_bit_cnt_nxt = 3'd0;
               w_state_nxt   = S_TX_STOP;
            end else begin
               w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end
         end
         // Stop bit occupies two edges: drive it, then hand over to the receiver.
         S_TX_STOP: begin
            w_mosi_nxt = STOP_BIT;
            if (r_bit_cnt == 3'd1) begin
               w_tmo_cnt_nxt = '0;
               w_state_nxt   = S_RESP_WAIT;
            end else begin
               w_bit_cnt_nxt = 3'd1;
            end
         end
         S_RESP_WAIT: begin
            if (bus.spi_miso == START_BIT) begin
               w_bit_cnt_nxt = 3'd0;
               w_state_nxt   = S_RESP_DATA;
            end else if (r_tmo_cnt == TCW'(TIMEOUT - 1)) begin
               w_finish  = 1'b1;
               w_fin_err = ERR_TIMEOUT;
            end else begin
               w_tmo_cnt_nxt = r_tmo_cnt + TCW'(1);
            end
         end
         S_RESP_DATA: begin
            w_rx_nxt = {r_rx[6:0], bus.spi_miso};
            if (r_bit_cnt == 3'd7) begin
               w_state_nxt = S_RESP_STOP;
            end else begin
               w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end
         end
         S_RESP_STOP: begin
            w_finish   = 1'b1;
            w_fin_data = r_rx;
            w_fin_err  = (bus.spi_miso == STOP_BIT) ? ERR_OK : ERR_FRAME;
         end
         S_GAP: begin
            if (r_gap_cnt == GCW'(GAP_CYCLES - 1)) begin
               w_state_nxt = S_IDLE;
               w_busy_nxt  = 1'b0;
            end else begin
               w_gap_cnt_nxt = r_gap_cnt + GCW'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_finish) begin
         w_resp_valid_nxt = 1'b1;
         w_resp_id_nxt    = r_id;
         w_resp_data_nxt  = w_fin_data;
         w_resp_err_nxt   = w_fin_err;
         w_cs_n_nxt       = 1'b1;
         w_gap_cnt_nxt    = '0;
         w_state_nxt      = S_GAP;
      end
   end

   // State and output registers, synchronous active-low reset.
   always_ff @(posedge spi_clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_ptr        <= IDW'(NREQ - 1);
         r_tx         <= '0;
         r_id         <= '0;
         r_bit_cnt    <= '0;
         r_tmo_cnt    <= '0;
         r_gap_cnt    <= '0;
         r_rx         <= '0;
         r_grant      <= '0;
         r_resp_valid <= 1'b0;
         r_resp_id    <= '0;
         r_resp_data  <= '0;
         r_resp_err   <= ERR_OK;
         r_busy       <= 1'b0;
         r_cs_n       <= 1'b1;
         r_mosi       <= 1'b1;
      end else begin
         r_state      <= w_state_nxt;
         r_ptr        <= w_ptr_nxt;
         r_tx         <= w_tx_nxt;
         r_id         <= w_id_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_tmo_cnt    <= w_tmo_cnt_nxt;
         r_gap_cnt    <= w_gap_cnt_nxt;
         r_rx         <= w_rx_nxt;
         r_grant      <= w_grant_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_resp_id    <= w_resp_id_nxt;
         r_resp_data  <= w_resp_data_nxt;
         r_resp_err   <= w_resp_err_nxt;
         r_busy       <= w_busy_nxt;
         r_cs_n       <= w_cs_n_nxt;
         r_mosi       <= w_mosi_nxt;
      end
   end

   assign bus.grant      = r_grant;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_id    = r_resp_id;
   assign bus.resp_data  = r_resp_data;
   assign bus.resp_err   = r_resp_err;
   assign bus.busy       = r_busy;
   assign bus.spi_cs_n   = r_cs_n;
   assign bus.spi_mosi   = r_mosi;

endmodule

// File: tb/tb_spi_link_sched.sv
// Directed bench for spi_link_sched: round robin, echo, timeout, framing,
// mid-frame reset and ignored requests while busy.
module tb_spi_link_sched;
   import spi_link_pkg::*;

   logic spi_clk = 1'b0;
   logic rst_n   = 1'b0;
   always #5 spi_clk = ~spi_clk;

   spi_link_sched_if #(.NREQ(2)) bus ();

   spi_link_sched #(.NREQ(2), .TIMEOUT(32), .GAP_CYCLES(2)) dut (
      .spi_clk (spi_clk),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   int         n_vec   = 0;
   int         n_miss  = 0;
   int         n_grant = 0;
   int         resp_cnt = 0;
   logic       last_id;
   logic [7:0] last_data;
   logic [1:0] last_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock; observe outputs at the falling edge.
   task automatic step();
      @(negedge spi_clk);
      if (bus.grant != 2'b00) n_grant++;
      if (bus.resp_valid) begin
         resp_cnt++;
         last_id   = bus.resp_id;
         last_data = bus.resp_data;
         last_err  = bus.resp_err;
      end
   endtask

   // Wait for a grant, capture the 10-bit MOSI frame, then play the peer.
   task automatic serve(input logic [7:0] echo, input logic stopb, input logic silent,
                        input logic drop, input logic pulse,
                        output logic [9:0] frame, output logic [1:0] g, output int wait_n);
      int n;
      int base;
      frame  = '0;
      g      = '0;
      wait_n = 0;
      n      = 0;
      do begin
         step();
         n++;
      end while (bus.grant == 2'b00 && n < 20);
      if (bus.grant == 2'b00) begin
         chk("grant_seen", 32'd0, 32'd1);
         return;
      end
      g     = bus.grant;
      frame = {9'b0, bus.spi_mosi};
      if (drop) bus.req_valid = bus.req_valid & ~g;
      for (int e = 1; e <= 9; e++) begin
         if (pulse && e == 3) bus.req_valid[1] = 1'b1;
         if (pulse && e == 5) bus.req_valid[1] = 1'b0;
         step();
         frame = {frame[8:0], bus.spi_mosi};
      end
      step();
      chk("cs_low_e10", 32'(bus.spi_cs_n), 32'd0);
      chk("mosi_high_e10", 32'(bus.spi_mosi), 32'd1);
      base = resp_cnt;
      for (int k = 1; k <= 60; k++) begin
         if (silent)       bus.spi_miso = 1'b1;
         else if (k == 1)  bus.spi_miso = 1'b0;
         else if (k <= 9)  bus.spi_miso = echo[3'(9 - k)];
         else if (k == 10) bus.spi_miso = stopb;
         else              bus.spi_miso = 1'b1;
         step();
         if (resp_cnt != base) begin
            wait_n = k;
            break;
         end
      end
      bus.spi_miso = 1'b1;
      if (wait_n == 0) chk("resp_seen", 32'd0, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] fr;
      logic [1:0] g;
      int         w;
      int         base;
      int         n;

      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.spi_miso  = 1'b1;

      repeat (3) step();
      chk("rst_cs_n",   32'(bus.spi_cs_n),   32'd1);
      chk("rst_mosi",   32'(bus.spi_mosi),   32'd1);
      chk("rst_grant",  32'(bus.grant),      32'd0);
      chk("rst_rvalid", 32'(bus.resp_valid), 32'd0);
      chk("rst_rdata",  32'(bus.resp_data),  32'd0);
      chk("rst_rerr",   32'(bus.resp_err),   32'd0);
      chk("rst_busy",   32'(bus.busy),       32'd0);
      rst_n = 1'b1;
      step();

      // Both requesters held: alternating service starting with requester 0.
      bus.req_valid = 2'b11;
      bus.req_data  = {8'h22, 8'h11};
      for (int i = 0; i < 4; i++) begin
         serve(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, fr, g, w);
         chk("rr_grant", 32'(g),         (i % 2 == 1) ? 32'h2 : 32'h1);
         chk("rr_frame", 32'(fr),        (i % 2 == 1) ? 32'h045 : 32'h023);
         chk("rr_id",    32'(last_id),   32'(i % 2));
         chk("rr_data",  32'(last_data), 32'h3C);
         chk("rr_err",   32'(last_err),  32'(ERR_OK));
      end
      bus.req_valid = 2'b00;

      // Single echo of 0xA9 plus gap timing.
      bus.req_valid = 2'b01;
      bus.req_data  = {8'h00, 8'hA9};
      serve(8'hA9, 1'b1, 1'b0, 1'b1, 1'b0, fr, g, w);
      chk("a9_grant", 32'(g),         32'h1);
      chk("a9_frame", 32'(fr),        32'h153);
      chk("a9_id",    32'(last_id),   32'd0);
      chk("a9_data",  32'(last_data), 32'hA9);
      chk("a9_err",   32'(last_err),  32'(ERR_OK));
      chk("a9_wait",  32'(w),         32'd10);
      chk("a9_cs_fin", 32'(bus.spi_cs_n), 32'd1);
      chk("a9_busy_fin", 32'(bus.busy), 32'd1);
      step();
      chk("gap1_rvalid", 32'(bus.resp_valid), 32'd0);
      chk("gap1_cs_n",   32'(bus.spi_cs_n),   32'd1);
      chk("gap1_busy",   32'(bus.busy),       32'd1);
      step();
      chk("gap2_cs_n",   32'(bus.spi_cs_n),   32'd1);
      chk("gap2_busy",   32'(bus.busy),       32'd0);

      // Silent peer.
      bus.req_valid = 2'b01;
      bus.req_data  = {8'h00, 8'h55};
      serve(8'h00, 1'b1, 1'b1, 1'b1, 1'b0, fr, g, w);
      chk("to_err",  32'(last_err),  32'(ERR_TIMEOUT));
      chk("to_data", 32'(last_data), 32'h00);
      chk("to_wait", 32'(w),         32'd32);
      chk("to_cs_n", 32'(bus.spi_cs_n), 32'd1);

      // Bad stop bit still delivers the byte.
      bus.req_valid = 2'b01;
      bus.req_data  = {8'h00, 8'h77};
      serve(8'h5C, 1'b0, 1'b0, 1'b1, 1'b0, fr, g, w);
      chk("fr_data", 32'(last_data), 32'h5C);
      chk("fr_err",  32'(last_err),  32'(ERR_FRAME));

      // Reset during transmit aborts without a response.
      bus.req_valid = 2'b01;
      bus.req_data  = {8'h00, 8'hF0};
      n = 0;
      do begin
         step();
         n++;
      end while (bus.grant == 2'b00 && n < 20);
      chk("rst_mid_grant", 32'(bus.grant), 32'h1);
      bus.req_valid = 2'b00;
      repeat (4) step();
      rst_n = 1'b0;
      base  = resp_cnt;
      step();
      chk("rst_mid_cs_n", 32'(bus.spi_cs_n), 32'd1);
      chk("rst_mid_mosi", 32'(bus.spi_mosi), 32'd1);
      chk("rst_mid_busy", 32'(bus.busy),     32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         bus.spi_miso = (k >= 10 && k < 20) ? 1'b0 : 1'b1;
         step();
      end
      bus.spi_miso = 1'b1;
      chk("rst_mid_noresp", 32'(resp_cnt - base), 32'd0);
      bus.req_valid = 2'b10;
      bus.req_data  = {8'h96, 8'h00};
      serve(8'h96, 1'b1, 1'b0, 1'b1, 1'b0, fr, g, w);
      chk("post_rst_grant", 32'(g),         32'h2);
      chk("post_rst_id",    32'(last_id),   32'd1);
      chk("post_rst_data",  32'(last_data), 32'h96);
      chk("post_rst_err",   32'(last_err),  32'(ERR_OK));

      // Requester 1 pulses only while busy: never granted.
      bus.req_valid = 2'b01;
      bus.req_data  = {8'hEE, 8'h0F};
      serve(8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, fr, g, w);
      chk("pulse_grant", 32'(g),       32'h1);
      chk("pulse_id",    32'(last_id), 32'd0);
      step();
      chk("pulse_gap1_cs_n", 32'(bus.spi_cs_n), 32'd1);
      step();
      chk("pulse_gap2_cs_n", 32'(bus.spi_cs_n), 32'd1);
      chk("pulse_gap2_busy", 32'(bus.busy),     32'd0);
      repeat (10) step();
      chk("grant_total", 32'(n_grant), 32'd10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
